// File: rtl/fir_par2ser.sv
// fir_par2ser: re-serialises 3-lane parallel FIR output triples into one time-ordered sample stream.
// Optional FIR_PAR2SER_SAT_EN: round-half-up shift by SHIFT, then saturate to OUT_W.
module fir_par2ser #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  din1,
  input  logic [IN_W-1:0]  din2,
  input  logic [IN_W-1:0]  din3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  logic [1:0] count_q, count_d, phase_q, phase_d;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IN_W-1:0] mem_q [2][3];
  logic [IN_W-1:0] sel;
  logic [OUT_W-1:0] conv;
  logic push, pop, rel;
  assign in_ready  = count_q < 2'd2;
  assign out_valid = count_q != 2'd0;
  assign out_last  = out_valid && phase_q == 2'd2;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign rel  = pop && phase_q == 2'd2;
  assign sel = phase_q == 2'd0 ? mem_q[rd_ptr_q][0] :
               phase_q == 2'd1 ? mem_q[rd_ptr_q][1] : mem_q[rd_ptr_q][2];
`ifdef FIR_PAR2SER_SAT_EN
  localparam int SW = (IN_W + 1 > OUT_W ? IN_W + 1 : OUT_W) + 1;
  logic signed [IN_W:0] rnd, sum, shr;
  logic signed [SW-1:0] ext, hi, lo;
  assign rnd = ((IN_W+1)'(1) << SHIFT) >> 1;
  assign sum = $signed({sel[IN_W-1], sel}) + rnd;
  assign shr = sum >>> SHIFT;
  assign ext = SW'(shr);
  assign hi  = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign lo  = ~hi;
  assign conv = ext > hi ? OUT_W'(hi) : ext < lo ? OUT_W'(lo) : OUT_W'(ext);
`else
  assign conv = OUT_W'($signed(sel));
`endif
  assign dout = out_valid ? conv : '0;
  always_comb begin
    count_d  = count_q + 2'(push) - 2'(rel);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ rel;
    phase_d  = pop ? (phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1) : phase_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      phase_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q][0] <= din1;
      mem_q[wr_ptr_q][1] <= din2;
      mem_q[wr_ptr_q][2] <= din3;
    end
  end
endmodule
